// File: rtl/native_rr_arbiter_pkg.sv
// Shared definitions for the native-bus round-robin arbiter: arbiter state
// encoding and helpers that derive packed request/response widths.
package native_rr_arbiter_pkg;

  typedef enum logic [0:0] {
    ArbIdle = 1'b0,
    ArbBusy = 1'b1
  } arb_state_e;

  // Request slice layout {valid, addr, wdata, wstrb}, MSB to LSB.
  function automatic int unsigned req_width(int unsigned addr_w, int unsigned data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  // Response slice layout {rdata, ready}, MSB to LSB.
  function automatic int unsigned resp_width(int unsigned data_w);
    return data_w + 1;
  endfunction

  // Grant index width, never narrower than one bit.
  function automatic int unsigned grant_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/native_rr_arbiter_rr_priority_sel.sv
// Rotating first-one finder: scans the request vector starting one past the
// previous owner and wrapping modulo N, so non-power-of-2 counts work.
module native_rr_arbiter_rr_priority_sel
  import native_rr_arbiter_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned W = grant_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = '0;
    idx    = 0;
    any    = |req;
    for (int k = int'(N); k >= 1; k--) begin
      idx = (int'(last) + k) % int'(N);
      if (req[idx]) begin
        winner = W'(idx);
      end
    end
  end

endmodule

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native-bus slave among N_MASTERS requesters.
// One transaction is owned at a time; the grant is held from acceptance until
// the slave's ready pulse, followed by one idle bubble before re-arbitration.
module native_rr_arbiter
  import native_rr_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTERS = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  localparam int unsigned REQ_W    = req_width(ADDR_W, DATA_W),
  localparam int unsigned RESP_W   = resp_width(DATA_W),
  localparam int unsigned GRANT_W  = grant_width(N_MASTERS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]    m_req,
  output logic [N_MASTERS*RESP_W-1:0]   m_resp,
  output logic [REQ_W-1:0]              s_req,
  input  logic [RESP_W-1:0]             s_resp,
  output logic [GRANT_W-1:0]            grant,
  output logic                          busy
);

  localparam int unsigned ValidBit = REQ_W - 1;
  localparam int unsigned ReadyBit = 0;

  arb_state_e           state_q;
  logic [GRANT_W-1:0]   grant_q;
  logic [GRANT_W-1:0]   last_q;
  logic [N_MASTERS-1:0] req_valid;
  logic [GRANT_W-1:0]   winner;
  logic                 any_req;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
    assign req_valid[i] = m_req[i*REQ_W + ValidBit];
  end

  native_rr_arbiter_rr_priority_sel #(
    .N (N_MASTERS)
  ) u_sel (
    .req    (req_valid),
    .last   (last_q),
    .winner (winner),
    .any    (any_req)
  );

  // Arbitration FSM: latch the winner in idle, hold ownership until ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      last_q  <= GRANT_W'(N_MASTERS - 1);
    end else begin
      case (state_q)
        ArbIdle: begin
          if (any_req) begin
            grant_q <= winner;
            state_q <= ArbBusy;
          end
        end
        ArbBusy: begin
          // Ready ends ownership; the next grant waits for the idle bubble.
          if (s_resp[ReadyBit]) begin
            last_q  <= grant_q;
            state_q <= ArbIdle;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  // Route the owner's request to the slave and the slave's response back.
  always_comb begin
    s_req  = '0;
    m_resp = '0;
    if (state_q == ArbBusy) begin
      s_req                            = m_req[grant_q*REQ_W +: REQ_W];
      m_resp[grant_q*RESP_W +: RESP_W] = s_resp;
    end
  end

  assign busy  = (state_q == ArbBusy);
  assign grant = grant_q;

endmodule

// File: tb/tb_native_rr_arbiter.sv
// Randomized bench for native_rr_arbiter (3 masters) against a transaction-level
// model: a rotating owner pointer, behavioural masters and a delayed-ready slave.
module tb_native_rr_arbiter;

  localparam int N      = 3;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int SW     = DW / 8;
  localparam int REQ_W  = 1 + AW + DW + SW;
  localparam int RESP_W = DW + 1;
  localparam int GW     = 2;

  logic                  clk;
  logic                  rst_n;
  logic [N*REQ_W-1:0]    m_req;
  logic [N*RESP_W-1:0]   m_resp;
  logic [REQ_W-1:0]      s_req;
  logic [RESP_W-1:0]     s_resp;
  logic [GW-1:0]         grant;
  logic                  busy;

  // Master-side stimulus state.
  logic          mv [N];
  logic [AW-1:0] ma [N];
  logic [DW-1:0] mw [N];
  logic [SW-1:0] ms [N];
  int            gap [N];

  // Slave-side stimulus.
  logic          sr_ready;
  logic [DW-1:0] sr_rdata;

  // Knobs.
  logic [N-1:0]  active;
  int            gap_lo, gap_hi, dly_lo, dly_hi, spur_pct;
  bit            rdata_fixed;
  logic [DW-1:0] rdata_val;

  // Reference model: owner pointer plus the previous owner for rotation.
  bit mdl_busy;
  bit mdl_entered;
  int mdl_owner;
  int mdl_last;
  int cnt;

  // Observations for directed checks.
  int             cyc;
  int             gnt_q[$];
  int             gnt_cyc_q[$];
  int             rdy_cnt[N];
  logic [DW-1:0]  last_rdata[N];
  logic [REQ_W-1:0] first_sreq;

  int checks;
  int errors;

  native_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .m_req  (m_req),
    .m_resp (m_resp),
    .s_req  (s_req),
    .s_resp (s_resp),
    .grant  (grant),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    m_req = '0;
    for (int i = 0; i < N; i++) begin
      m_req[i*REQ_W +: REQ_W] = {mv[i], ma[i], mw[i], ms[i]};
    end
  end

  assign s_resp = {sr_rdata, sr_ready};

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic new_txn(input int i);
    mv[i] = 1'b1;
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = SW'($urandom);
  endtask

  // One clock of checking plus model/stimulus advance.
  task automatic run(input int n);
    logic [REQ_W-1:0]    exp_sreq;
    logic [N*RESP_W-1:0] exp_resp;
    bit                  nbusy;
    int                  nowner, nlast, j;
    logic                nready;
    logic [DW-1:0]       nrdata;
    bit                  done [N];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      exp_sreq = '0;
      exp_resp = '0;
      if (mdl_busy) begin
        exp_sreq = {mv[mdl_owner], ma[mdl_owner], mw[mdl_owner], ms[mdl_owner]};
        exp_resp[mdl_owner*RESP_W +: RESP_W] = s_resp;
      end
      check_eq("busy", 128'(busy), 128'(mdl_busy));
      if (mdl_busy) check_eq("grant", 128'(grant), 128'(mdl_owner));
      check_eq("s_req", 128'(s_req), 128'(exp_sreq));
      check_eq("m_resp", 128'(m_resp), 128'(exp_resp));

      if (mdl_busy && mdl_entered) begin
        if (gnt_q.size() == 0) first_sreq = s_req;
        gnt_q.push_back(int'(grant));
        gnt_cyc_q.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
        if (m_resp[i*RESP_W]) begin
          rdy_cnt[i]++;
          last_rdata[i] = m_resp[i*RESP_W+1 +: DW];
        end
      end

      // Next model state.
      nbusy  = mdl_busy;
      nowner = mdl_owner;
      nlast  = mdl_last;
      if (!mdl_busy) begin
        for (int k = 1; k <= N; k++) begin
          j = (mdl_last + k) % N;
          if (mv[j] && !nbusy) begin
            nbusy  = 1'b1;
            nowner = j;
          end
        end
      end else if (s_resp[0]) begin
        nbusy = 1'b0;
        nlast = mdl_owner;
      end
      for (int i = 0; i < N; i++) done[i] = mdl_busy && (mdl_owner == i) && s_resp[0];

      // Slave: ready after a chosen number of owned cycles, or spurious in idle.
      if (nbusy) begin
        if (!mdl_busy) cnt = $urandom_range(dly_hi, dly_lo);
        nready = (cnt == 0);
        if (cnt > 0) cnt--;
      end else begin
        nready = (int'($urandom_range(99, 0)) < spur_pct);
      end
      nrdata = rdata_fixed ? rdata_val : $urandom;

      @(posedge clk);
      mdl_entered = nbusy && !mdl_busy;
      mdl_busy    = nbusy;
      mdl_owner   = nowner;
      mdl_last    = nlast;
      #1;
      sr_ready = nready;
      sr_rdata = nrdata;
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          mv[i]  = 1'b0;
          gap[i] = $urandom_range(gap_hi, gap_lo);
        end
        if (!mv[i] && active[i]) begin
          if (gap[i] == 0) new_txn(i);
          else gap[i]--;
        end
      end
    end
  endtask

  // Assert reset mid-cycle, check outputs immediately and across an edge,
  // then release just after a rising edge.
  task automatic apply_reset(input logic [N-1:0] vmask);
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vmask[i] && !mv[i]) new_txn(i);
      else if (!vmask[i]) mv[i] = 1'b0;
      gap[i] = 0;
    end
    sr_ready = 1'b1;
    sr_rdata = $urandom;
    #1;
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_s_req", 128'(s_req), 128'(0));
    check_eq("rst_m_resp", 128'(m_resp), 128'(0));
    mdl_busy    = 1'b0;
    mdl_entered = 1'b0;
    mdl_owner   = 0;
    mdl_last    = N - 1;
    @(posedge clk);
    #1;
    check_eq("rst_hold_busy", 128'(busy), 128'(0));
    check_eq("rst_hold_m_resp", 128'(m_resp), 128'(0));
    check_eq("rst_grant", 128'(grant), 128'(0));
    rst_n    = 1'b1;
    sr_ready = 1'b0;
    gnt_q.delete();
    gnt_cyc_q.delete();
    for (int i = 0; i < N; i++) rdy_cnt[i] = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < N; i++) begin
      mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0; gap[i] = 0;
      rdy_cnt[i] = 0; last_rdata[i] = '0;
    end
    sr_ready = 1'b0; sr_rdata = '0;
    cnt = 0; first_sreq = '0;
    rdata_fixed = 1'b0; rdata_val = '0;

    // Reset with every master valid, then strict rotation under contention.
    active = 3'b111; gap_lo = 0; gap_hi = 0; dly_lo = 1; dly_hi = 1; spur_pct = 0;
    apply_reset(3'b111);
    run(18);
    check_eq("cont_count", 128'(gnt_q.size()), 128'(6));
    for (int k = 0; k < 6 && k < gnt_q.size(); k++) begin
      check_eq("cont_grant", 128'(gnt_q[k]), 128'(k % N));
      if (k > 0) check_eq("cont_txn_len", 128'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 128'(3));
    end

    // Single read from m0; slave answers three cycles after valid appears.
    active = 3'b001; gap_lo = 1000; gap_hi = 1000; dly_lo = 3; dly_hi = 3;
    rdata_fixed = 1'b1; rdata_val = 32'hDEADBEEF;
    apply_reset(3'b001);
    ma[0] = 32'h100;
    run(12);
    check_eq("rd_m0_ready_cnt", 128'(rdy_cnt[0]), 128'(1));
    check_eq("rd_m1_ready_cnt", 128'(rdy_cnt[1]), 128'(0));
    check_eq("rd_m0_rdata", 128'(last_rdata[0]), 128'(32'hDEADBEEF));

    // Write pass-through from m1.
    active = 3'b010; dly_lo = 2; dly_hi = 2; rdata_fixed = 1'b0;
    apply_reset(3'b010);
    mw[1] = 32'h12345678;
    ms[1] = 4'b0011;
    run(8);
    check_eq("wr_grant", 128'(gnt_q.size() > 0 ? gnt_q[0] : -1), 128'(1));
    check_eq("wr_valid", 128'(first_sreq[REQ_W-1]), 128'(1));
    check_eq("wr_data_strb", 128'(first_sreq[DW+SW-1:0]), 128'({32'h12345678, 4'b0011}));

    // Spurious ready while nobody requests.
    active = 3'b000; spur_pct = 100;
    apply_reset(3'b000);
    run(8);
    check_eq("spur_ready_cnt", 128'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2]), 128'(0));
    check_eq("spur_no_grant", 128'(gnt_q.size()), 128'(0));

    // Randomized traffic with mid-transaction resets.
    active = 3'b111; gap_lo = 0; gap_hi = 3; dly_lo = 0; dly_hi = 3; spur_pct = 30;
    apply_reset(3'b111);
    for (int seg = 0; seg < 6; seg++) begin
      active = 3'($urandom_range(7, 1));
      run(500);
      active = 3'b111;
      for (int t = 0; t < 20 && !mdl_busy; t++) run(1);
      check_eq("pre_rst_busy", 128'(busy), 128'(1));
      apply_reset(3'b111);
      spur_pct = 0;
      run(3);
      spur_pct = 30;
      check_eq("restart_grant", 128'(gnt_q.size() > 0 ? gnt_q[0] : -1), 128'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
